dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences every data-memory access of the core between the decoder's DMEM controls and the DMEM bus.
//  Takes mem_write, mem_read, d_size and d_unsigned from the decoder; rejects misaligned accesses.
//  Handles the bus handshake: request hold until grant, then a read-response wait.
//  Stalls the pipeline while an access is outstanding; returns load data already aligned and extended.
// PARAMETERS
//  XLEN        32   data/address width
//  TIMEOUT     255  max cycles in REQ+WAIT_R before bus-error abort (>=1)
// PORTS
//  i_clk            in   1     clock
//  i_rst_n          in   1     asynchronous active-low reset
//  i_valid          in   1     EX/MEM stage holds a valid instruction
//  i_mem_write      in   1     store (priority over i_mem_read)
//  i_mem_read       in   1     load
//  i_d_size         in   2     00 byte, 01 half, 10 word, 11 illegal
//  i_d_unsigned     in   1     zero-extend load
//  i_addr           in   XLEN  byte address
//  i_wdata          in   XLEN  store data (LSBs significant)
//  o_stall          out  1     hold pipeline
//  o_done           out  1     one-cycle completion pulse
//  o_rdata          out  XLEN  extended load data, valid with o_done
//  o_misaligned     out  1     one-cycle pulse: access rejected
//  o_bus_err        out  1     one-cycle pulse, with o_done: timeout abort
//  o_dmem_req       out  1     bus request
//  o_dmem_we        out  1     write
//  o_dmem_addr      out  XLEN  word-aligned address {i_addr[XLEN-1:2],2'b00}
//  o_dmem_be        out  4     byte enables
//  o_dmem_wdata     out  XLEN  lane-replicated store data
//  i_dmem_gnt       in   1     request accepted this cycle
//  i_dmem_rvalid    in   1     read data valid
//  i_dmem_rdata     in   XLEN  raw word
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state IDLE; all outputs 0; req drops immediately, including mid-access.
//  New op = i_valid & (i_mem_write | i_mem_read).
//  Misaligned = size 11 | (half & addr[0]) | (word & addr[1:0]!=0).
//  FSM IDLE/REQ/WAIT_R/DONE:
//   IDLE: new op & misaligned -> o_misaligned=1 same cycle, no stall, no bus, stay IDLE.
//         new op aligned -> o_stall=1; register op, addr, be, wdata, size, unsigned, offset; -> REQ.
//   REQ:  o_dmem_req=1, bus outputs from registers, stable until gnt; o_stall=1.
//         gnt & store -> DONE.
//         gnt & load & rvalid same cycle -> capture data, -> DONE.
//         gnt & load otherwise -> WAIT_R.
//   WAIT_R: req=0, o_stall=1; rvalid -> capture extended data into o_rdata, -> DONE.
//   DONE: o_done=1, o_stall=0 (pipeline advances); o_rdata held; i_valid ignored; -> IDLE.
//  Latency: zero-wait store = 3 cycles IDLE->DONE; load = 3 + response wait.
//  Timeout: counter clears on leaving IDLE, counts each cycle in REQ/WAIT_R.
//   On reaching TIMEOUT: -> DONE, o_bus_err=1, o_rdata=0, req dropped.
//  rvalid outside WAIT_R/REQ-with-gnt: ignored. gnt while req=0: ignored.
//  Byte enables: byte 0001<<off; half 0011<<off; word 1111.
//  Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
//  Load data: lane = rdata>>(8*off); byte/half sign- or zero-extended per unsigned; word passthrough.
//  o_rdata resets to 0 and changes only on capture or timeout.
// STRUCTURE
//  Package dmem_pkg: SIZE_BYTE/HALF/WORD constants, state enum, be/replicate functions.
//  Sub-module dmem_load_align: combinational rdata, offset, size, unsigned -> extended XLEN word.
//  FSM, timeout counter and registered request live in this module.
// TESTING
//  lw 0x100, gnt cycle 1, rvalid 2 cycles later, rdata 0xDEADBEEF -> be=1111, o_rdata=0xDEADBEEF,
//   o_done once, o_stall high until DONE.
//  lb 0x103 signed, rdata 0x80xxxxxx -> be=1000, o_rdata=0xFFFFFF80; lbu -> 0x00000080.
//  sh 0x102 wdata 0x1234ABCD, gnt after 4 cycles -> req held 5 cycles, be=1100, wdata=0xABCDABCD,
//   addr 0x100, o_done 1 cycle after gnt.
//  lw 0x101 / lh 0x203 / size 11 -> o_misaligned pulse, no req, no stall.
//  Load, gnt, no rvalid for TIMEOUT=8 -> o_bus_err+o_done, o_rdata=0, back to IDLE.
//  i_rst_n low during REQ/WAIT_R -> req/stall 0 immediately; next op completes normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
// Access sizes, FSM state encoding and lane/byte-enable helpers.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_DONE
    } state_t;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return (size == 2'b11) ||
               ((size == SIZE_HALF) && off[0]) ||
               ((size == SIZE_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return 4'b0011 << off;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        case (size)
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data lane selection and sign/zero extension.
// Purely combinational; fed from the registered access descriptor.
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] lane;
    logic            sext;

    // Shift the addressed lane down to bit 0, then extend by size.
    always_comb begin
        lane = rdata >> {off, 3'b000};
        sext = 1'b0;
        data = lane;
        case (size)
            SIZE_BYTE: begin
                sext = ~uns & lane[7];
                data = {{(XLEN-8){sext}}, lane[7:0]};
            end
            SIZE_HALF: begin
                sext = ~uns & lane[15];
                data = {{(XLEN-16){sext}}, lane[15:0]};
            end
            default: data = lane;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer between decoder controls and the DMEM bus.
// Registers one access, runs the req/gnt/rvalid handshake and stalls meanwhile.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_mem_write,
    input  logic            i_mem_read,
    input  logic [1:0]      i_d_size,
    input  logic            i_d_unsigned,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_misaligned,
    output logic            o_bus_err,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic            we_q, uns_q, err_q;
    logic [1:0]      size_q, off_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]      be_q;
    logic [CW-1:0]   cnt_q;

    logic            new_op, mis, tmo;
    logic            accept, capture, abort;
    logic [XLEN-1:0] load_data;

    // Reset gating keeps every output low while reset is held.
    assign new_op = i_rst_n & i_valid & (i_mem_write | i_mem_read);
    assign mis    = is_misaligned(i_d_size, i_addr[1:0]);
    assign tmo    = (cnt_q == CW'(TIMEOUT - 1));

    dmem_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .rdata (i_dmem_rdata),
        .off   (off_q),
        .size  (size_q),
        .uns   (uns_q),
        .data  (load_data)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state, handshake outputs and capture/abort strobes.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        capture      = 1'b0;
        abort        = 1'b0;
        o_stall      = 1'b0;
        o_dmem_req   = 1'b0;
        o_done       = 1'b0;
        o_misaligned = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_op && mis) begin
                    o_misaligned = 1'b1;
                end else if (new_op) begin
                    accept  = 1'b1;
                    o_stall = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                o_dmem_req = 1'b1;
                o_stall    = 1'b1;
                if (i_dmem_gnt && (we_q || i_dmem_rvalid)) begin
                    capture = ~we_q;
                    state_d = ST_DONE;
                end else if (tmo) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end else if (i_dmem_gnt) begin
                    state_d = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (tmo) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the access descriptor when an aligned op is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= i_mem_write;
            uns_q   <= i_d_unsigned;
            size_q  <= i_d_size;
            off_q   <= i_addr[1:0];
            addr_q  <= {i_addr[XLEN-1:2], 2'b00};
            be_q    <= byte_en(i_d_size, i_addr[1:0]);
            wdata_q <= replicate(i_d_size, i_wdata);
        end
    end

    // Timeout counter: cleared on accept, counts every REQ/WAIT_R cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= '0;
        else if (state_q == ST_REQ || state_q == ST_WAIT_R)
            cnt_q <= cnt_q + CW'(1);
    end

    // Load result and bus-error flag; rdata moves only on capture/abort.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept)  err_q <= 1'b0;
            if (abort)   err_q <= 1'b1;
            if (capture) rdata_q <= load_data;
            else if (abort) rdata_q <= '0;
        end
    end

    assign o_rdata      = rdata_q;
    assign o_bus_err    = o_done & err_q;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;

endmodule
